accel_blk_buf: RTL and testbench

- Accelerator-side block buffer that sits directly upstream of the memory request arbiter.
- Loads one signal chunk from host memory into a local block RAM through the arbiter's accelerator read handshake, then lends the RAM to the FT core for compute.
- Once the core reports completion, writes the chunk back to host memory through the arbiter's accelerator write handshake.
- Owns the accelDataRd/accelDataWr/sigNum request side of the arbiter interface.

---
 rtl/accel_blk_buf.sv | 163 ++++++++++++++++
 tb/tb_accel_blk_buf.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_blk_buf.sv
// Block buffer between the FT core and the memory request arbiter: load a chunk, lend it to the core, write it back.
// Define ACCEL_BLK_BUF_PERF_EN to add the loadCycles/storeCycles performance counters.
module accel_blk_buf #(
    parameter int BLK_W    = 512,
    parameter int NUM_BLKS = 32,
    parameter int SIG_W    = 18,
    localparam int AW      = $clog2(NUM_BLKS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SIG_W-1:0] sigNumIn,
    input  logic             computeDone,
    output logic             loadDone,
    output logic             xferDone,
    output logic             busy,
    input  logic [AW-1:0]    bufRdAddr,
    output logic [BLK_W-1:0] bufRdData,
    input  logic             bufWrEn,
    input  logic [AW-1:0]    bufWrAddr,
    input  logic [BLK_W-1:0] bufWrData,
    output logic             accelDataRd,
    output logic             accelDataWr,
    output logic [SIG_W-1:0] sigNum,
    output logic [BLK_W-1:0] accelBlk2Mem,
    input  logic [BLK_W-1:0] accelBlk2Buffer,
    input  logic             accelRdBlkDone,
    input  logic             accelWrBlkDone
`ifdef ACCEL_BLK_BUF_PERF_EN
    ,
    output logic [31:0]      loadCycles,
    output logic [31:0]      storeCycles
`endif
);

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, STORE, DONE} stateT;

    localparam logic [AW-1:0] LAST_BLK = AW'(NUM_BLKS - 1);

    stateT            state;
    stateT            nextState;
    logic [AW-1:0]    blkCnt;
    logic             lastBlk;
    logic             startAccept;
    logic             rdAccept;
    logic             wrAccept;
    logic [BLK_W-1:0] mem [NUM_BLKS];

    assign lastBlk = (blkCnt == LAST_BLK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Requests are masked by rst so they drop in the very cycle reset is sampled.
    always_comb begin
        nextState   = state;
        startAccept = 1'b0;
        rdAccept    = 1'b0;
        wrAccept    = 1'b0;
        accelDataRd = 1'b0;
        accelDataWr = 1'b0;
        xferDone    = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    startAccept = 1'b1;
                    nextState   = LOAD;
                end
            end
            LOAD: begin
                accelDataRd = !rst;
                rdAccept    = accelRdBlkDone;
                if (accelRdBlkDone && lastBlk) begin
                    nextState = COMPUTE;
                end
            end
            COMPUTE: begin
                if (computeDone) begin
                    nextState = STORE;
                end
            end
            STORE: begin
                accelDataWr = !rst;
                wrAccept    = accelWrBlkDone;
                if (accelWrBlkDone && lastBlk) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                xferDone  = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // blkCnt wraps to 0 after the last block since NUM_BLKS is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            blkCnt   <= '0;
            sigNum   <= '0;
            loadDone <= 1'b0;
        end else begin
            loadDone <= rdAccept && lastBlk;
            if (startAccept) begin
                sigNum <= sigNumIn;
                blkCnt <= '0;
            end else if (rdAccept || wrAccept) begin
                blkCnt <= blkCnt + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (rdAccept) begin
                mem[blkCnt] <= accelBlk2Buffer;
            end else if (state == COMPUTE && bufWrEn) begin
                mem[bufWrAddr] <= bufWrData;
            end
        end
    end

    // Read-before-write: a same-address read in the write cycle returns the old block.
    always_ff @(posedge clk) begin
        if (rst) begin
            bufRdData <= '0;
        end else if (state == COMPUTE) begin
            bufRdData <= mem[bufRdAddr];
        end
    end

    assign accelBlk2Mem = (state == STORE) ? mem[blkCnt] : '0;

`ifdef ACCEL_BLK_BUF_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            loadCycles  <= '0;
            storeCycles <= '0;
        end else if (startAccept) begin
            loadCycles  <= '0;
            storeCycles <= '0;
        end else begin
            if (state == LOAD && loadCycles != 32'hFFFF_FFFF) begin
                loadCycles <= loadCycles + 32'd1;
            end
            if (state == STORE && storeCycles != 32'hFFFF_FFFF) begin
                storeCycles <= storeCycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_accel_blk_buf.sv
// Self-checking bench for accel_blk_buf: acts as the arbiter and the FT core, with a chunk-level memory model.
// Perf counter checks are compiled in when ACCEL_BLK_BUF_PERF_EN is defined.
module tb_accel_blk_buf;

    localparam int BLK_W    = 32;
    localparam int NUM_BLKS = 4;
    localparam int SIG_W    = 18;
    localparam int AW       = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [SIG_W-1:0] sigNumIn;
    logic             computeDone;
    logic             loadDone;
    logic             xferDone;
    logic             busy;
    logic [AW-1:0]    bufRdAddr;
    logic [BLK_W-1:0] bufRdData;
    logic             bufWrEn;
    logic [AW-1:0]    bufWrAddr;
    logic [BLK_W-1:0] bufWrData;
    logic             accelDataRd;
    logic             accelDataWr;
    logic [SIG_W-1:0] sigNum;
    logic [BLK_W-1:0] accelBlk2Mem;
    logic [BLK_W-1:0] accelBlk2Buffer;
    logic             accelRdBlkDone;
    logic             accelWrBlkDone;
`ifdef ACCEL_BLK_BUF_PERF_EN
    logic [31:0]      loadCycles;
    logic [31:0]      storeCycles;
`endif

    accel_blk_buf #(.BLK_W(BLK_W), .NUM_BLKS(NUM_BLKS), .SIG_W(SIG_W)) dut (
        .clk(clk), .rst(rst), .start(start), .sigNumIn(sigNumIn),
        .computeDone(computeDone), .loadDone(loadDone), .xferDone(xferDone), .busy(busy),
        .bufRdAddr(bufRdAddr), .bufRdData(bufRdData), .bufWrEn(bufWrEn),
        .bufWrAddr(bufWrAddr), .bufWrData(bufWrData),
        .accelDataRd(accelDataRd), .accelDataWr(accelDataWr), .sigNum(sigNum),
        .accelBlk2Mem(accelBlk2Mem), .accelBlk2Buffer(accelBlk2Buffer),
        .accelRdBlkDone(accelRdBlkDone), .accelWrBlkDone(accelWrBlkDone)
`ifdef ACCEL_BLK_BUF_PERF_EN
        , .loadCycles(loadCycles), .storeCycles(storeCycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             wrEn;
        logic [AW-1:0]    wrAddr;
        logic [BLK_W-1:0] wrData;
        logic [AW-1:0]    rdAddr;
        logic [BLK_W-1:0] expRd;
    } vecT;

    int               checks = 0;
    int               errors = 0;
    int               overlapCnt = 0;
    logic [BLK_W-1:0] model [NUM_BLKS];
    logic [BLK_W-1:0] loadBlks [NUM_BLKS];
    int               loadLat [NUM_BLKS];
    int               storeLat [NUM_BLKS];
    logic [SIG_W-1:0] expSig;
    logic [BLK_W-1:0] expRdData;
    int               expLoadCycles;
    int               expStoreCycles;
    vecT              vecs [6];

    always @(negedge clk) begin
        if (accelDataRd && accelDataWr) overlapCnt++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clearCore();
        start          = 1'b0;
        computeDone    = 1'b0;
        bufWrEn        = 1'b0;
        bufRdAddr      = '0;
        accelRdBlkDone = 1'b0;
        accelWrBlkDone = 1'b0;
    endtask

    // Core and arbiter noise that must be ignored outside the owning state.
    task automatic driveJunk(input bit inStore);
        bufWrEn     = 1'($urandom);
        bufWrAddr   = AW'($urandom);
        bufWrData   = $urandom;
        bufRdAddr   = AW'($urandom);
        computeDone = ($urandom_range(0, 3) == 0);
        if (inStore) begin
            accelRdBlkDone  = 1'($urandom);
            accelBlk2Buffer = $urandom;
        end
    endtask

    // One COMPUTE cycle: drive a core read/write, check the read one cycle later, then update the model.
    task automatic applyStimulus(input vecT v);
        bufWrEn   = v.wrEn;
        bufWrAddr = v.wrAddr;
        bufWrData = v.wrData;
        bufRdAddr = v.rdAddr;
        nextCycle();
        bufWrEn = 1'b0;
        checkOutput("coreRead", bufRdData, v.expRd);
        if (v.wrEn) model[v.wrAddr] = v.wrData;
        expRdData = v.expRd;
    endtask

    task automatic startChunk(input logic [SIG_W-1:0] sig);
        sigNumIn = sig;
        start    = 1'b1;
        expSig   = sig;
        nextCycle();
        start    = 1'b0;
        sigNumIn = SIG_W'($urandom);
        checkOutput("busyAfterStart", 32'(busy), 32'd1);
    endtask

    task automatic setRandomChunk(input int maxLat);
        for (int i = 0; i < NUM_BLKS; i++) begin
            loadBlks[i] = $urandom;
            loadLat[i]  = $urandom_range(0, maxLat);
            storeLat[i] = $urandom_range(0, maxLat);
        end
    endtask

    // Arbiter read side: answers each request after loadLat[i] cycles.
    task automatic arbLoad(input int strayAt, input bit junk);
        int waitCnt;
        int rdDrop;
        rdDrop = 0;
        expLoadCycles = 0;
        for (int i = 0; i < NUM_BLKS; i++) begin
            waitCnt = 0;
            while (!accelDataRd && waitCnt < 100) begin
                nextCycle();
                waitCnt++;
            end
            if (!accelDataRd) begin
                checkOutput("loadReqTimeout", 32'd0, 32'd1);
                clearCore();
                return;
            end
            for (int k = 0; k < loadLat[i]; k++) begin
                if (junk) driveJunk(1'b0);
                if (i == strayAt && k == 0) begin
                    start          = 1'b1;
                    sigNumIn       = 18'h00009;
                    accelWrBlkDone = 1'b1;
                end
                nextCycle();
                start          = 1'b0;
                accelWrBlkDone = 1'b0;
                if (!accelDataRd) rdDrop++;
            end
            if (junk) driveJunk(1'b0);
            accelRdBlkDone  = 1'b1;
            accelBlk2Buffer = loadBlks[i];
            nextCycle();
            accelRdBlkDone  = 1'b0;
            accelBlk2Buffer = $urandom;
            expLoadCycles += loadLat[i] + 1;
            model[i] = loadBlks[i];
        end
        clearCore();
        checkOutput("rdLowAfterLast", 32'(accelDataRd), 32'd0);
        checkOutput("loadDonePulse", 32'(loadDone), 32'd1);
        checkOutput("rdHeldInLoad", 32'(rdDrop), 32'd0);
        checkOutput("sigNumLoad", 32'(sigNum), 32'(expSig));
        checkOutput("rdDataHoldLoad", bufRdData, expRdData);
`ifdef ACCEL_BLK_BUF_PERF_EN
        checkOutput("loadCycles", loadCycles, 32'(expLoadCycles));
`endif
        nextCycle();
        expRdData = model[0];
        checkOutput("loadDoneOnce", 32'(loadDone), 32'd0);
        checkOutput("busyCompute", 32'(busy), 32'd1);
    endtask

    // Arbiter write side: acks each block after storeLat[i] cycles; abortAfter resets mid-chunk.
    task automatic arbStore(input int abortAfter, input bit junk);
        int waitCnt;
        int wrDrop;
        int unstable;
        wrDrop = 0;
        unstable = 0;
        expStoreCycles = 0;
        bufRdAddr   = AW'($urandom);
        expRdData   = model[bufRdAddr];
        computeDone = 1'b1;
        nextCycle();
        computeDone = 1'b0;
        for (int i = 0; i < NUM_BLKS; i++) begin
            waitCnt = 0;
            while (!accelDataWr && waitCnt < 100) begin
                nextCycle();
                waitCnt++;
            end
            if (!accelDataWr) begin
                checkOutput("storeReqTimeout", 32'd0, 32'd1);
                clearCore();
                return;
            end
            if (i == abortAfter) begin
                clearCore();
                rst = 1'b1;
                #1;
                checkOutput("wrDropInReset", 32'(accelDataWr), 32'd0);
                nextCycle();
                rst = 1'b0;
                expRdData = '0;
                checkOutput("wrLowAfterReset", 32'(accelDataWr), 32'd0);
                checkOutput("busyAfterReset", 32'(busy), 32'd0);
                checkOutput("sigNumAfterReset", 32'(sigNum), 32'd0);
                return;
            end
            for (int k = 0; k < storeLat[i]; k++) begin
                if (junk) driveJunk(1'b1);
                if (accelBlk2Mem !== model[i]) unstable++;
                nextCycle();
                if (!accelDataWr) wrDrop++;
            end
            if (junk) driveJunk(1'b1);
            checkOutput("storeBlk", accelBlk2Mem, model[i]);
            accelWrBlkDone = 1'b1;
            nextCycle();
            accelWrBlkDone = 1'b0;
            expStoreCycles += storeLat[i] + 1;
        end
        clearCore();
        checkOutput("wrLowAfterLast", 32'(accelDataWr), 32'd0);
        checkOutput("xferDonePulse", 32'(xferDone), 32'd1);
        checkOutput("storeBlkStable", 32'(unstable), 32'd0);
        checkOutput("wrHeldInStore", 32'(wrDrop), 32'd0);
        checkOutput("sigNumStore", 32'(sigNum), 32'(expSig));
        checkOutput("rdDataHoldStore", bufRdData, expRdData);
`ifdef ACCEL_BLK_BUF_PERF_EN
        checkOutput("storeCycles", storeCycles, 32'(expStoreCycles));
`endif
        nextCycle();
        checkOutput("xferDoneOnce", 32'(xferDone), 32'd0);
        checkOutput("busyIdle", 32'(busy), 32'd0);
`ifdef ACCEL_BLK_BUF_PERF_EN
        nextCycle();
        checkOutput("loadCyclesHold", loadCycles, 32'(expLoadCycles));
        checkOutput("storeCyclesHold", storeCycles, 32'(expStoreCycles));
`endif
    endtask

    task automatic randomCompute(input int n);
        vecT v;
        for (int j = 0; j < n; j++) begin
            v.wrEn   = 1'($urandom);
            v.wrAddr = AW'($urandom);
            v.wrData = $urandom;
            v.rdAddr = AW'($urandom);
            v.expRd  = model[v.rdAddr];
            applyStimulus(v);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 2'd2, 32'h0000_BEEF, 2'd2, 32'h0000_00A2};
        vecs[1] = '{1'b0, 2'd0, 32'h0,         2'd2, 32'h0000_BEEF};
        vecs[2] = '{1'b1, 2'd0, 32'h0000_1234, 2'd1, 32'h0000_00A1};
        vecs[3] = '{1'b0, 2'd0, 32'h0,         2'd0, 32'h0000_1234};
        vecs[4] = '{1'b1, 2'd0, 32'h0000_00A0, 2'd3, 32'h0000_00A3};
        vecs[5] = '{1'b0, 2'd0, 32'h0,         2'd0, 32'h0000_00A0};

        rst = 1'b1;
        sigNumIn = '0;
        bufWrAddr = '0;
        bufWrData = '0;
        accelBlk2Buffer = '0;
        clearCore();
        expSig = '0;
        expRdData = '0;
        repeat (2) nextCycle();
        rst = 1'b0;
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstLoadDone", 32'(loadDone), 32'd0);
        checkOutput("rstXferDone", 32'(xferDone), 32'd0);
        checkOutput("rstRd", 32'(accelDataRd), 32'd0);
        checkOutput("rstWr", 32'(accelDataWr), 32'd0);
        checkOutput("rstSigNum", 32'(sigNum), 32'd0);
        checkOutput("rstBufRdData", bufRdData, 32'd0);
        checkOutput("rstBlk2Mem", accelBlk2Mem, 32'd0);

        // Directed chunk: A0..A3, 3-cycle reads with stray start/write-ack, table in COMPUTE, 2-cycle writes.
        $display("[TB] directed chunk");
        for (int i = 0; i < NUM_BLKS; i++) begin
            loadBlks[i] = 32'hA0 + 32'(i);
            loadLat[i]  = 3;
            storeLat[i] = 2;
        end
        startChunk(18'h00005);
        arbLoad(1, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);
        arbStore(-1, 1'b0);

        // Reset in STORE after two blocks, then a fresh chunk from block 0.
        $display("[TB] reset mid-store");
        setRandomChunk(3);
        startChunk(18'h00003);
        arbLoad(-1, 1'b0);
        arbStore(2, 1'b0);
        setRandomChunk(3);
        startChunk(18'h00007);
        arbLoad(-1, 1'b0);
        randomCompute(4);
        arbStore(-1, 1'b0);

        // Back-to-back read and write acks.
        $display("[TB] back-to-back");
        setRandomChunk(0);
        startChunk(SIG_W'($urandom));
        arbLoad(-1, 1'b0);
        randomCompute(2);
        arbStore(-1, 1'b0);

        $display("[TB] random chunks");
        for (int r = 0; r < 6; r++) begin
            setRandomChunk(4);
            startChunk(SIG_W'($urandom));
            arbLoad(-1, 1'b1);
            randomCompute(8);
            arbStore(-1, 1'b1);
        end

`ifdef ACCEL_BLK_BUF_PERF_EN
        $display("[TB] load counter saturation");
        startChunk(18'h00011);
        nextCycle();
        force dut.loadCycles = 32'hFFFF_FFFE;
        nextCycle();
        release dut.loadCycles;
        repeat (3) nextCycle();
        checkOutput("loadCyclesSat", loadCycles, 32'hFFFF_FFFF);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
`endif

        checkOutput("reqOverlap", 32'(overlapCnt), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
